// File: rtl/rom_stream_reader.sv
// Streams a programmed burst of ROM words to a valid/ready consumer, hiding the
// ROM's one-cycle read latency behind a small credit-managed output FIFO.
module rom_stream_reader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 24,
  parameter int DEPTH  = 4,
  parameter int LEN_W  = 15
) (
  input  logic              CK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE,
  input  logic [LEN_W-1:0]  LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] ROM_A,
  output logic              ROM_OE,
  input  logic [DATA_W-1:0] ROM_Q,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                       state_q;
  logic [ADDR_W-1:0]            addr_q;
  logic [LEN_W-1:0]             rem_q;
  logic                         inflight_q;
  logic                         done_q;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [PW-1:0]                wptr_q, rptr_q;
  logic [CW-1:0]                cnt_q, cnt_d;

  logic          push, pop, issue;
  logic [CW:0]   credit;
  logic [PW-1:0] wptr_nx, rptr_nx;

  // Credit counts the word already on its way out of the ROM, so issue depends
  // only on registered state and never on OUT_READY.
  always_comb begin
    credit  = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
    issue   = (state_q == RUN) && (credit < (CW+1)'(DEPTH));
    push    = inflight_q;
    pop     = (cnt_q != '0) && OUT_READY;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    wptr_nx = (wptr_q == PW'(DEPTH-1)) ? '0 : wptr_q + 1'b1;
    rptr_nx = (rptr_q == PW'(DEPTH-1)) ? '0 : rptr_q + 1'b1;
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      mem_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      cnt_q      <= cnt_d;
      if (push) begin
        mem_q[wptr_q] <= ROM_Q;
        wptr_q        <= wptr_nx;
      end
      if (pop) rptr_q <= rptr_nx;

      case (state_q)
        IDLE: begin
          if (START) begin
            if (LEN != '0) begin
              addr_q  <= BASE;
              rem_q   <= LEN;
              state_q <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr_q <= addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // cnt_q == 0 also rules out a pop at this edge.
          if (!inflight_q && (cnt_q == '0)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUSY      = (state_q != IDLE);
  assign ROM_OE    = (state_q != IDLE);
  assign DONE      = done_q;
  assign ROM_A     = addr_q;
  assign OUT_DATA  = mem_q[rptr_q];
  assign OUT_VALID = (cnt_q != '0);

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed and randomized bursts against a queue-based expectation of which
// ROM words must reach the consumer, in what order, and when.
module tb_rom_stream_reader;
  localparam int DEPTH = 4;

  logic        CK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [13:0] BASE = '0;
  logic [14:0] LEN = '0;
  logic        BUSY, DONE, ROM_OE, OUT_VALID;
  logic [13:0] ROM_A;
  logic [23:0] ROM_Q, OUT_DATA;
  logic        OUT_READY = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  rom_stream_reader #(.ADDR_W(14), .DATA_W(24), .DEPTH(DEPTH), .LEN_W(15)) dut (
    .CK(CK), .RST_N(RST_N), .START(START), .BASE(BASE), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .ROM_A(ROM_A), .ROM_OE(ROM_OE), .ROM_Q(ROM_Q),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  always #5 CK = ~CK;

  // ROM: mem[i] = i*3, address latched on CK rise, data driven while OE high.
  logic [13:0] rom_a_q = '0;
  always @(posedge CK) rom_a_q <= ROM_A;
  assign ROM_Q = ROM_OE ? 24'(int'(rom_a_q) * 3) : 24'hxxxxxx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, BUSY}, 0);
    chk({tag, "_done"}, {31'd0, DONE}, 0);
    chk({tag, "_oe"}, {31'd0, ROM_OE}, 0);
    chk({tag, "_rom_a"}, {18'd0, ROM_A}, 0);
    chk({tag, "_valid"}, {31'd0, OUT_VALID}, 0);
    chk({tag, "_data"}, {8'd0, OUT_DATA}, 0);
  endtask

  // mode 0: ready always 1; 1: random 50%; 2: ready 0 until cycle 12, then 1.
  task automatic burst(input logic [13:0] base, input int len, input int mode,
                       input bit poke, input int abort_after,
                       output int first_v, output int first_w, output int last_w);
    logic [23:0] exp_q[$];
    int got, k, issued;
    bit fin, aborted;
    got = 0; first_v = -1; first_w = -1; last_w = -1; fin = 0; aborted = 0;
    for (int i = 0; i < len; i++) exp_q.push_back(24'(((int'(base) + i) % 16384) * 3));
    @(negedge CK);
    START = 1'b1; BASE = base; LEN = 15'(len); OUT_READY = (mode == 0);
    @(negedge CK);
    START = 1'b0; BASE = 14'($urandom); LEN = 15'($urandom);
    k = 1;
    chk("start_rom_a", {18'd0, ROM_A}, {18'd0, base});
    chk("start_busy", {31'd0, BUSY & ROM_OE}, 1);
    while (!fin && k < 2000) begin
      if (abort_after != 0 && got == abort_after) begin
        RST_N = 1'b0;
        #1;
        chk_idle_outputs("abort");
        aborted = 1;
        break;
      end
      if (first_v < 0 && OUT_VALID) first_v = k;
      if (mode == 1) OUT_READY = 1'($urandom_range(0, 1));
      else if (mode == 2) OUT_READY = (k > 12);
      else OUT_READY = 1'b1;
      if (poke && k == 4) begin START = 1'b1; BASE = 14'h2000; LEN = 15'd3; end
      else START = 1'b0;
      if (mode == 2 && k == 12) begin
        chk("stall_rom_a", {18'd0, ROM_A}, 32'((int'(base) + DEPTH) % 16384));
        chk("stall_hold", {8'd0, OUT_DATA}, {8'd0, exp_q[0]});
        chk("stall_valid", {31'd0, OUT_VALID}, 1);
      end
      if (BUSY) begin
        issued = (int'(ROM_A) - int'(base) + 16384) % 16384;
        chk("outstanding_le_depth", {31'd0, (issued - got) <= DEPTH}, 1);
      end
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) chk("extra_word", {8'd0, OUT_DATA}, 32'hFFFFFFFF);
        else chk("data", {8'd0, OUT_DATA}, {8'd0, exp_q.pop_front()});
        got++;
        if (first_w < 0) first_w = k;
        last_w = k;
      end
      if (DONE) begin
        chk("done_busy", {31'd0, BUSY}, 0);
        chk("done_count", got, len);
        fin = 1;
      end
      @(negedge CK);
      k++;
    end
    START = 1'b0;
    if (!aborted) begin
      if (!fin) chk("timeout", 0, 1);
      chk("done_pulse", {31'd0, DONE}, 0);
      repeat (3) @(negedge CK);
      chk("after_valid", {31'd0, OUT_VALID}, 0);
      chk("after_busy", {31'd0, BUSY}, 0);
    end
  endtask

  int fv, fw, lw;

  initial begin
    #1;
    chk_idle_outputs("reset");
    repeat (2) @(negedge CK);
    RST_N = 1'b1;

    // Full-rate burst: first data two edges after START, 8 back-to-back words.
    burst(14'h0010, 8, 0, 0, 0, fv, fw, lw);
    chk("t1_first_valid", fv, 3);
    chk("t1_consecutive", lw - fw, 7);

    // Address wrap at the top of the ROM.
    burst(14'h3FFE, 4, 0, 0, 0, fv, fw, lw);
    chk("wrap_consecutive", lw - fw, 3);

    // Back-pressure for 10 cycles, then release.
    burst(14'h0010, 8, 2, 0, 0, fv, fw, lw);
    chk("stall_first_valid", fv, 3);

    // Random back-pressure, with a START poked mid-burst that must be ignored.
    burst(14'($urandom), 100, 1, 1, 0, fv, fw, lw);

    // Zero-length burst.
    @(negedge CK);
    START = 1'b1; LEN = 15'd0; BASE = 14'h0123;
    @(negedge CK);
    START = 1'b0;
    chk("len0_done", {31'd0, DONE}, 1);
    chk("len0_oe", {31'd0, ROM_OE}, 0);
    chk("len0_valid", {31'd0, OUT_VALID}, 0);
    @(negedge CK);
    chk("len0_done_pulse", {31'd0, DONE}, 0);
    chk("len0_busy", {31'd0, BUSY}, 0);

    // Reset mid-burst after 3 words; no DONE, then a clean new burst.
    burst(14'h0100, 20, 0, 0, 3, fv, fw, lw);
    repeat (2) begin
      @(negedge CK);
      chk("abort_no_done", {31'd0, DONE}, 0);
      chk("abort_valid", {31'd0, OUT_VALID}, 0);
    end
    RST_N = 1'b1;
    @(negedge CK);
    chk("post_abort_done", {31'd0, DONE}, 0);
    chk("post_abort_busy", {31'd0, BUSY}, 0);
    burst(14'h0200, 5, 1, 0, 0, fv, fw, lw);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
